// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store front end for a byte-addressed memory. Accepts one request at a
// time, performs loads with sign/zero extension, word stores directly, and
// byte/halfword stores as a read-modify-write of the containing 32-bit word.
// Out-of-range addresses and the illegal size encoding are rejected without
// touching memory.
//
// Configuration macro:
//   MISALIGN_TRAP_EN  when defined, misaligned halfword/word requests are
//                     rejected as errors; when undefined they are performed
//                     normally (the memory is byte-addressed).
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous active-low reset
//   req_valid      request present
//   req_ready      unit idle and able to accept a request
//   req_write      1 = store, 0 = load
//   req_size       00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned   zero-extend loads when 1, sign-extend when 0
//   req_addr       byte address
//   req_wdata      store data, right-aligned
//   resp_valid     one-cycle completion pulse
//   resp_rdata     extended load data (0 for stores and errors)
//   resp_err       request rejected, valid with resp_valid
//   mem_address    memory byte address
//   mem_writeData  word written to memory
//   mem_memRead    memory read strobe
//   mem_memWrite   memory write strobe
//   mem_memData    combinational read data {addr+3..addr}
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memRead,
    output logic        mem_memWrite,
    input  logic [31:0] mem_memData
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RMW_READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [1:0]  SIZE_ILL  = 2'b11;
    // Highest address whose full 4-byte window still lies inside memory.
    localparam logic [31:0] MAX_ADDR  = 32'(MEM_BYTES - 4);

    state_t      state;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [15:0] wdata_q;     // only the sub-word store path needs held data

    logic        accept;
    logic        misaligned;
    logic        bad_req;

    // Ready is gated by reset so it drops the instant reset asserts and rises
    // in the first cycle after release, without waiting for a clock edge.
    assign req_ready = (state == IDLE) && reset;
    assign accept    = req_valid && req_ready;

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        case (req_size)
            SIZE_HALF: misaligned = req_addr[0];
            SIZE_WORD: misaligned = (req_addr[1:0] != 2'b00);
            default:   misaligned = 1'b0;
        endcase
`endif
        bad_req = (req_size == SIZE_ILL) || (req_addr > MAX_ADDR) || misaligned;
    end

    function automatic logic [31:0] load_extend(input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] res;
        case (size)
            SIZE_BYTE: res = uns ? {24'h0, data[7:0]}  : {{24{data[7]}}, data[7:0]};
            SIZE_HALF: res = uns ? {16'h0, data[15:0]} : {{16{data[15]}}, data[15:0]};
            default:   res = data;
        endcase
        return res;
    endfunction

    // Keep the bytes above the store width from the word just read.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [15:0] wdata,
                                                input logic [1:0]  size);
        return (size == SIZE_BYTE) ? {old_word[31:8],  wdata[7:0]}
                                   : {old_word[31:16], wdata[15:0]};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the block order does not matter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            size_q        <= SIZE_BYTE;
            unsigned_q    <= 1'b0;
            wdata_q       <= '0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            mem_address   <= '0;
            mem_writeData <= '0;
            mem_memRead   <= 1'b0;
            mem_memWrite  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata[15:0];
                        if (bad_req) begin
                            // Rejected: straight to the response, no strobes.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (!req_write) begin
                            mem_address <= req_addr;
                            mem_memRead <= 1'b1;
                            state       <= READ;
                        end else if (req_size == SIZE_WORD) begin
                            mem_address   <= req_addr;
                            mem_writeData <= req_wdata;
                            mem_memWrite  <= 1'b1;
                            state         <= WRITE;
                        end else begin
                            mem_address <= req_addr;
                            mem_memRead <= 1'b1;
                            state       <= RMW_READ;
                        end
                    end
                end

                READ: begin
                    resp_rdata  <= load_extend(mem_memData, size_q, unsigned_q);
                    resp_valid  <= 1'b1;
                    mem_memRead <= 1'b0;
                    mem_address <= '0;
                    state       <= RESP;
                end

                RMW_READ: begin
                    // Read strobe drops as write rises: never both in a cycle.
                    mem_memRead   <= 1'b0;
                    mem_memWrite  <= 1'b1;
                    mem_writeData <= merge_store(mem_memData, wdata_q, size_q);
                    state         <= WRITE;
                end

                WRITE: begin
                    mem_memWrite  <= 1'b0;
                    mem_writeData <= '0;
                    mem_address   <= '0;
                    resp_valid    <= 1'b1;
                    state         <= RESP;
                end

                RESP: begin
                    // No backpressure: the pulse lasts exactly one cycle.
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed testbench for mem_access_unit with a 256-byte behavioural memory.
// Expected values are hand-computed from the initial memory image
// (byte i = i, with a few bytes overridden below).
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic [31:0] mem_memData;

    int n_cmp = 0;
    int n_bad = 0;
    int both_cnt = 0;

    // Results of the last do_req call.
    logic [31:0] r_rdata;
    logic        r_err;
    int          r_lat;
    int          r_rd;
    int          r_wr;
    logic        r_ready_resp;
    logic [31:0] r_addr_resp;

    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(256)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_memRead   (mem_memRead),
        .mem_memWrite  (mem_memWrite),
        .mem_memData   (mem_memData)
    );

    // Behavioural byte-addressed memory: combinational read, write on edge.
    logic [7:0] a0, a1, a2, a3;
    assign a0 = mem_address[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;
    assign mem_memData = mem_memRead ? {mem[a3], mem[a2], mem[a1], mem[a0]} : 32'h0;

    always @(posedge clk) begin
        if (mem_memWrite) begin
            mem[a0] <= mem_writeData[7:0];
            mem[a1] <= mem_writeData[15:8];
            mem[a2] <= mem_writeData[23:16];
            mem[a3] <= mem_writeData[31:24];
        end
    end

    always @(negedge clk) begin
        if (mem_memRead && mem_memWrite) both_cnt++;
    end

    task automatic idle_inputs();
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
    endtask

    // Present one request, then wait (bounded) for its response, counting
    // cycles after the accepting edge and memory strobes seen on the way.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        idle_inputs();
        r_lat = 0; r_rd = 0; r_wr = 0; r_rdata = 32'h0; r_err = 1'b0;
        r_ready_resp = 1'b1; r_addr_resp = 32'hFFFF_FFFF;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_memRead)  r_rd++;
            if (mem_memWrite) r_wr++;
            if (resp_valid) begin
                r_lat        = i;
                r_rdata      = resp_rdata;
                r_err        = resp_err;
                r_ready_resp = req_ready;
                r_addr_resp  = mem_address;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, mem_address,
             mem_writeData, mem_memRead, mem_memWrite} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ready=%b rv=%b err=%b rdata=%h addr=%h wd=%h rd=%b wr=%b want all 0",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_address,
                     mem_writeData, mem_memRead, mem_memWrite);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_load();
        do_req(1'b0, 2'b00, 1'b0, 32'd150, 32'h0);
        n_cmp++;
        if ({r_rdata, r_err, r_lat[3:0], r_rd[3:0], r_wr[3:0]} !== {32'hFFFFFF87, 1'b0, 4'd2, 4'd1, 4'd0}) begin
            n_bad++;
            $display("FAIL lb_150: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want ffffff87/0/2/1/0",
                     r_rdata, r_err, r_lat, r_rd, r_wr);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'd150, 32'h0);
        n_cmp++;
        if ({r_rdata, r_err, r_lat[3:0]} !== {32'h00000087, 1'b0, 4'd2}) begin
            n_bad++;
            $display("FAIL lbu_150: got rdata=%h err=%b lat=%0d want 00000087/0/2", r_rdata, r_err, r_lat);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'd150, 32'h0);
        n_cmp++;
        if ({r_rdata, r_err} !== {32'hFFFF9787, 1'b0}) begin
            n_bad++;
            $display("FAIL lh_150: got rdata=%h err=%b want ffff9787/0", r_rdata, r_err);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'd150, 32'h0);
        n_cmp++;
        if ({r_rdata, r_err} !== {32'h00009787, 1'b0}) begin
            n_bad++;
            $display("FAIL lhu_150: got rdata=%h err=%b want 00009787/0", r_rdata, r_err);
        end
        // req_unsigned has no effect on words.
        do_req(1'b0, 2'b10, 1'b1, 32'd160, 32'h0);
        n_cmp++;
        if ({r_rdata, r_err, r_addr_resp} !== {32'h11223344, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL lw_160: got rdata=%h err=%b resp_addr=%h want 11223344/0/0",
                     r_rdata, r_err, r_addr_resp);
        end
    endtask

    task automatic test_store();
        // Upper half of wdata must be ignored by a halfword store.
        do_req(1'b1, 2'b01, 1'b0, 32'd160, 32'hDEADBEEF);
        n_cmp++;
        if ({r_rdata, r_err, r_lat[3:0], r_rd[3:0], r_wr[3:0]} !== {32'h0, 1'b0, 4'd3, 4'd1, 4'd1}) begin
            n_bad++;
            $display("FAIL sh_160: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want 0/0/3/1/1",
                     r_rdata, r_err, r_lat, r_rd, r_wr);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'd160, 32'h0);
        n_cmp++;
        if (r_rdata !== 32'h1122BEEF) begin
            n_bad++;
            $display("FAIL sh_160_readback: got %h want 1122beef", r_rdata);
        end
        do_req(1'b1, 2'b00, 1'b0, 32'd164, 32'h12345655);
        do_req(1'b0, 2'b10, 1'b0, 32'd164, 32'h0);
        n_cmp++;
        if (r_rdata !== 32'hA7A6A555) begin
            n_bad++;
            $display("FAIL sb_164_readback: got %h want a7a6a555", r_rdata);
        end
        do_req(1'b1, 2'b10, 1'b0, 32'd200, 32'hCAFEF00D);
        n_cmp++;
        if ({r_err, r_lat[3:0], r_rd[3:0], r_wr[3:0]} !== {1'b0, 4'd2, 4'd0, 4'd1}) begin
            n_bad++;
            $display("FAIL sw_200: got err=%b lat=%0d rd=%0d wr=%0d want 0/2/0/1", r_err, r_lat, r_rd, r_wr);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'd200, 32'h0);
        n_cmp++;
        if (r_rdata !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL sw_200_readback: got %h want cafef00d", r_rdata);
        end
    endtask

    task automatic test_errors();
        do_req(1'b0, 2'b10, 1'b0, 32'd253, 32'h0);
        n_cmp++;
        if ({r_rdata, r_err, r_lat[3:0], r_rd[3:0], r_wr[3:0]} !== {32'h0, 1'b1, 4'd1, 4'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL lw_253_range: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want 0/1/1/0/0",
                     r_rdata, r_err, r_lat, r_rd, r_wr);
        end
        do_req(1'b0, 2'b11, 1'b0, 32'd0, 32'h0);
        n_cmp++;
        if ({r_rdata, r_err, r_lat[3:0], r_rd[3:0], r_wr[3:0]} !== {32'h0, 1'b1, 4'd1, 4'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL size_11: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want 0/1/1/0/0",
                     r_rdata, r_err, r_lat, r_rd, r_wr);
        end
        do_req(1'b1, 2'b10, 1'b0, 32'd253, 32'h01020304);
        n_cmp++;
        if ({r_err, r_lat[3:0], r_wr[3:0]} !== {1'b1, 4'd1, 4'd0}) begin
            n_bad++;
            $display("FAIL sw_253_range: got err=%b lat=%0d wr=%0d want 1/1/0", r_err, r_lat, r_wr);
        end
        // Last legal word address; also shows the rejected store wrote nothing.
        do_req(1'b0, 2'b10, 1'b0, 32'd252, 32'h0);
        n_cmp++;
        if ({r_rdata, r_err, r_lat[3:0]} !== {32'hFFFEFDFC, 1'b0, 4'd2}) begin
            n_bad++;
            $display("FAIL lw_252_edge: got rdata=%h err=%b lat=%0d want fffefdfc/0/2", r_rdata, r_err, r_lat);
        end
    endtask

    task automatic test_misalign();
        do_req(1'b0, 2'b10, 1'b0, 32'd2, 32'h0);
        n_cmp++;
`ifdef MISALIGN_TRAP_EN
        if ({r_rdata, r_err, r_lat[3:0], r_rd[3:0]} !== {32'h0, 1'b1, 4'd1, 4'd0}) begin
            n_bad++;
            $display("FAIL lw_2_trap: got rdata=%h err=%b lat=%0d rd=%0d want 0/1/1/0", r_rdata, r_err, r_lat, r_rd);
        end
`else
        if ({r_rdata, r_err, r_lat[3:0]} !== {32'h05040302, 1'b0, 4'd2}) begin
            n_bad++;
            $display("FAIL lw_2_misaligned: got rdata=%h err=%b lat=%0d want 05040302/0/2", r_rdata, r_err, r_lat);
        end
`endif
        do_req(1'b0, 2'b01, 1'b1, 32'd161, 32'h0);
        n_cmp++;
`ifdef MISALIGN_TRAP_EN
        if ({r_rdata, r_err} !== {32'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL lhu_161_trap: got rdata=%h err=%b want 0/1", r_rdata, r_err);
        end
`else
        if ({r_rdata, r_err} !== {32'h000022BE, 1'b0}) begin
            n_bad++;
            $display("FAIL lhu_161_misaligned: got rdata=%h err=%b want 000022be/0", r_rdata, r_err);
        end
`endif
    endtask

    task automatic test_back_to_back();
        do_req(1'b0, 2'b10, 1'b0, 32'd160, 32'h0);
        n_cmp++;
        if (r_ready_resp !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_in_resp: got %b want 0", r_ready_resp);
        end
        // Present the next request while still in RESP; it must wait for IDLE.
        req_valid = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'd200;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, mem_memRead, resp_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL b2b_idle_cycle: got ready=%b rd=%b rv=%b want 1/0/0", req_ready, mem_memRead, resp_valid);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({resp_valid, resp_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            n_bad++;
            $display("FAIL b2b_second_resp: got rv=%b rdata=%h want 1/cafef00d", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_resp;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'd170;
        req_wdata = 32'h000000AA;
        @(posedge clk);
        #1;
        idle_inputs();
        n_cmp++;
        if (mem_memRead !== 1'b1) begin
            n_bad++;
            $display("FAIL rmw_read_entered: got rd=%b want 1", mem_memRead);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, mem_memRead, mem_memWrite, mem_address, mem_writeData} !== '0) begin
            n_bad++;
            $display("FAIL reset_async_clear: got ready=%b rd=%b wr=%b addr=%h wd=%h want all 0",
                     req_ready, mem_memRead, mem_memWrite, mem_address, mem_writeData);
        end
        seen_resp = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_midreset: got %b want 1", req_ready);
        end
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        n_cmp++;
        if (seen_resp !== 1'b0) begin
            n_bad++;
            $display("FAIL no_resp_after_abort: got %b want 0", seen_resp);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'd168, 32'h0);
        n_cmp++;
        if (r_rdata !== 32'hAB3CA9A8) begin
            n_bad++;
            $display("FAIL byte_170_unchanged: got %h want ab3ca9a8", r_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i[7:0];
        mem[150] = 8'h87;
        mem[160] = 8'h44;
        mem[161] = 8'h33;
        mem[162] = 8'h22;
        mem[163] = 8'h11;
        mem[170] = 8'h3C;

        test_reset();
        test_load();
        test_store();
        test_errors();
        test_misalign();
        test_back_to_back();
        test_reset_mid();

        n_cmp++;
        if (both_cnt !== 0) begin
            n_bad++;
            $display("FAIL rd_wr_exclusive: got %0d overlapping cycles want 0", both_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
